vec_sweep_ctrl: RTL

Sequencer that drives exhaustive 4-input stimulus into a small combinational power-experiment sub-circuit and profiles its switching activity. It walks all 16 input vectors in binary or Gray order, holds each for a programmable settle time, and samples the 1-bit response. It accumulates input-toggle, output-toggle and ones counts plus a 16-bit truth-table signature. It sits between the experiment harness (start/result side) and the sub-circuit under measurement (vec_out/resp_in side).

---
 rtl/vec_sweep_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vec_sweep_ctrl.sv
// vec_sweep_ctrl: walks all 16 4-bit input vectors (binary or Gray order) into a
//   small combinational sub-circuit, holds each for SETTLE+1 cycles, samples the
//   1-bit response and profiles switching activity.
// Latency: busy from the cycle after an accepted start; done pulses 16*(SETTLE+1)+1
//   cycles after start. Backpressure: none; start is ignored while a sweep runs,
//   and abort cancels the sweep on the next cycle.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, abort      sweep control (abort wins over start in IDLE)
//   mode              0 = binary order, 1 = Gray order (latched on accepted start)
//   vec_out, resp_in  stimulus to / response from the sub-circuit
//   busy, done        sweep in progress / one-cycle completion pulse
//   sig               truth-table signature, bit v = response for vector v
//   in_toggles        summed Hamming distance between consecutive vectors
//   out_toggles       response changes between consecutive samples
//   ones_count        number of samples equal to 1
module vec_sweep_ctrl #(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  output logic [3:0]       vec_out,
  input  logic             resp_in,
  output logic             busy,
  output logic             done,
  output logic [15:0]      sig,
  output logic [CNT_W-1:0] in_toggles,
  output logic [CNT_W-1:0] out_toggles,
  output logic [CNT_W-1:0] ones_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  logic [1:0] state;
  logic [3:0] step;      // index k of the vector currently driven
  logic [3:0] hold;      // cycles left before sampling the current vector
  logic       mode_q;
  logic       prev_resp; // response of the previous sample

  logic [3:0] vec_prev;
  logic [2:0] step_dist;
  logic       sample_now;

  function automatic logic [3:0] order_of(input logic [3:0] k, input logic gray);
    return gray ? (k ^ (k >> 1)) : k;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  // Saturating add: an overflow into the extra top bit pins the counter at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(b);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // vec_out always equals order(step) while holding, so the distance to the
  // previous vector only needs order(step-1); unused when step is 0.
  always_comb begin
    vec_prev   = order_of(step - 4'd1, mode_q);
    step_dist  = popcount4(vec_out ^ vec_prev);
    sample_now = (state == S_HOLD) && (hold == 4'd0) && !abort;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      step        <= 4'd0;
      hold        <= 4'd0;
      mode_q      <= 1'b0;
      prev_resp   <= 1'b0;
      vec_out     <= 4'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sig         <= 16'd0;
      in_toggles  <= '0;
      out_toggles <= '0;
      ones_count  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            state       <= S_HOLD;
            busy        <= 1'b1;
            mode_q      <= mode;
            step        <= 4'd0;
            hold        <= SETTLE_L;
            vec_out     <= order_of(4'd0, mode);
            prev_resp   <= 1'b0;
            sig         <= 16'd0;
            in_toggles  <= '0;
            out_toggles <= '0;
            ones_count  <= '0;
          end
        end

        S_HOLD: begin
          if (abort) begin
            // Partial results are kept; only the sequencing is torn down.
            state   <= S_IDLE;
            busy    <= 1'b0;
            vec_out <= 4'd0;
          end else if (!sample_now) begin
            hold <= hold - 4'd1;
          end else begin
            sig[vec_out] <= resp_in;
            prev_resp    <= resp_in;
            if (resp_in) begin
              ones_count <= sat_add(ones_count, 3'd1);
            end
            if (step != 4'd0) begin
              in_toggles <= sat_add(in_toggles, step_dist);
              if (resp_in != prev_resp) begin
                out_toggles <= sat_add(out_toggles, 3'd1);
              end
            end
            if (step != 4'd15) begin
              step    <= step + 4'd1;
              vec_out <= order_of(step + 4'd1, mode_q);
              hold    <= SETTLE_L;
            end else begin
              state   <= S_FIN;
              busy    <= 1'b0;
              done    <= 1'b1;
              vec_out <= 4'd0;
            end
          end
        end

        S_FIN: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          vec_out <= 4'd0;
        end
      endcase
    end
  end

endmodule
